// File: rtl/axis_slave_sink.sv
// AXI4-Stream sink: FWFT capture FIFO, beat/packet counters, sticky protocol error; beats readable right after acceptance.
// tready drops while full (no pass-through); define AXIS_SINK_THROTTLE_EN for LFSR-driven pseudo-random backpressure.
module axis_slave_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tid,
  input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_tdata,
  output logic [DATA_WIDTH/8-1:0]   rd_tkeep,
  output logic                      rd_tlast,
  output logic [USER_WIDTH-1:0]     rd_tuser,
  output logic [$clog2(DEPTH):0]    level,
  output logic [31:0]               beat_count,
  output logic [15:0]               pkt_count,
  output logic                      proto_err
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KW-1:0]         tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  entry_t        rd_entry;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   beat_count_q, beat_count_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic          proto_err_q, proto_err_d;
  logic          ready_en_q, ready_en_d;
  logic          full, empty, throttle_ok, push, pop, bad_beat;

  // Stream ID and routing are observed but never stored.
  logic          unused_sideband;
  assign unused_sideband = ^{s_axis_tid, s_axis_tdest};

`ifdef AXIS_SINK_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (ready_en_q) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 8'hFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign throttle_ok = (lfsr_q[1:0] != 2'b00);
`else
  assign throttle_ok = 1'b1;
`endif

  assign full          = (level_q == LW'(DEPTH));
  assign empty         = (level_q == '0);
  assign s_axis_tready = ready_en_q && !full && throttle_ok;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = !empty && rd_ready;
  assign bad_beat      = (|(s_axis_tstrb & ~s_axis_tkeep)) || (s_axis_tkeep == '0);

  always_comb begin
    wr_entry.tdata = s_axis_tdata;
    wr_entry.tkeep = s_axis_tkeep;
    wr_entry.tlast = s_axis_tlast;
    wr_entry.tuser = s_axis_tuser;
  end

  always_comb begin
    ready_en_d   = 1'b1;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    beat_count_d = beat_count_q;
    pkt_count_d  = pkt_count_q;
    proto_err_d  = proto_err_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      beat_count_d = beat_count_q + 32'd1;
      if (s_axis_tlast) pkt_count_d = pkt_count_q + 16'd1;
      if (bad_beat) proto_err_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      beat_count_q <= '0;
      pkt_count_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      ready_en_q   <= ready_en_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      beat_count_q <= beat_count_d;
      pkt_count_q  <= pkt_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Storage is deliberately not reset; rd_* is only meaningful with rd_valid.
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign rd_entry   = mem_q[rd_ptr_q];
  assign rd_valid   = !empty;
  assign rd_tdata   = rd_entry.tdata;
  assign rd_tkeep   = rd_entry.tkeep;
  assign rd_tlast   = rd_entry.tlast;
  assign rd_tuser   = rd_entry.tuser;
  assign level      = level_q;
  assign beat_count = beat_count_q;
  assign pkt_count  = pkt_count_q;
  assign proto_err  = proto_err_q;

endmodule
